press_classifier: RTL and testbench



---
 rtl/press_classifier.sv | 143 ++++++++++++++
 tb/tb_press_classifier.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/press_classifier.sv
// Turns a debounced switch level into short/long/repeat/double-click pulses.
// One FSM plus one shared cycle counter; all outputs are registered.
module press_classifier #(
  parameter int LONG_CYCLES   = 50000000,
  parameter int GAP_CYCLES    = 25000000,
  parameter int REPEAT_CYCLES = 10000000,
  parameter int CNT_W         = 26
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       enable,
  input  logic       btn_state,
  output logic       short_press,
  output logic       long_press,
  output logic       repeat_pulse,
  output logic       double_click,
  output logic       held,
  output logic [2:0] dbg_state
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_PRESS1    = 3'd1;
  localparam logic [2:0] S_WAIT      = 3'd2;
  localparam logic [2:0] S_PRESS2    = 3'd3;
  localparam logic [2:0] S_LONG_HOLD = 3'd4;

  // The sample that enters PRESS1/WAIT_SECOND counts towards its limit, and the
  // counter reads 0 on the first sample after entry, hence the "-2" limits.
  localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_CYCLES - 2);
  localparam logic [CNT_W-1:0] GAP_LAST    = CNT_W'(GAP_CYCLES - 2);
  localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};

  logic [2:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_btn_prev;
  logic             r_short;
  logic             r_long;
  logic             r_repeat;
  logic             r_double;
  logic             r_held;

  logic [2:0] w_state_nxt;
  logic       w_cnt_clr;
  logic       w_rise;
  logic       w_fall;
  logic       w_short;
  logic       w_long;
  logic       w_repeat;
  logic       w_double;

  assign w_rise = btn_state & ~r_btn_prev;
  assign w_fall = ~btn_state & r_btn_prev;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_clr   = 1'b0;
    w_short     = 1'b0;
    w_long      = 1'b0;
    w_repeat    = 1'b0;
    w_double    = 1'b0;
    if (!enable) begin
      w_state_nxt = S_IDLE;
      w_cnt_clr   = 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_cnt_clr = 1'b1;
          if (w_rise) w_state_nxt = S_PRESS1;
        end
        S_PRESS1: begin
          // A fall on the threshold sample wins over the long press.
          if (w_fall) begin
            w_state_nxt = S_WAIT;
          end else if (btn_state && r_cnt == LONG_LAST) begin
            w_long      = 1'b1;
            w_state_nxt = S_LONG_HOLD;
          end
        end
        S_WAIT: begin
          // A rise on the expiry sample wins over the short press.
          if (w_rise) begin
            w_state_nxt = S_PRESS2;
          end else if (r_cnt == GAP_LAST) begin
            w_short     = 1'b1;
            w_state_nxt = S_IDLE;
          end
        end
        S_PRESS2: begin
          if (w_fall) begin
            w_double    = 1'b1;
            w_state_nxt = S_IDLE;
          end
        end
        S_LONG_HOLD: begin
          if (w_fall) begin
            w_state_nxt = S_IDLE;
          end else if (r_cnt == REPEAT_LAST) begin
            w_repeat  = 1'b1;
            w_cnt_clr = 1'b1;
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
    if (w_state_nxt != r_state) w_cnt_clr = 1'b1;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_btn_prev <= 1'b1;
      r_short    <= 1'b0;
      r_long     <= 1'b0;
      r_repeat   <= 1'b0;
      r_double   <= 1'b0;
      r_held     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_btn_prev <= btn_state;
      r_short    <= w_short;
      r_long     <= w_long;
      r_repeat   <= w_repeat;
      r_double   <= w_double;
      r_held     <= (w_state_nxt == S_PRESS1) || (w_state_nxt == S_PRESS2) ||
                    (w_state_nxt == S_LONG_HOLD);
      if (w_cnt_clr) begin
        r_cnt <= '0;
      end else if (r_cnt != CNT_MAX) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign short_press  = r_short;
  assign long_press   = r_long;
  assign repeat_pulse = r_repeat;
  assign double_click = r_double;
  assign held         = r_held;
  assign dbg_state    = r_state;

endmodule

// File: tb/tb_press_classifier.sv
// Bench for press_classifier: directed tables, reset/enable sequences and a
// randomized run checked against a run-length reference model.
module tb_press_classifier;

  localparam int LONG = 8;
  localparam int GAP  = 4;
  localparam int REP  = 3;
  localparam int RN   = 600;

  // Expected output word: {held, double_click, repeat_pulse, long_press, short_press}
  localparam logic [4:0] E0 = 5'b00000;
  localparam logic [4:0] ES = 5'b00001;
  localparam logic [4:0] EL = 5'b00010;
  localparam logic [4:0] ER = 5'b00100;
  localparam logic [4:0] ED = 5'b01000;
  localparam logic [4:0] EH = 5'b10000;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       enable = 1'b1;
  logic       btn_state = 1'b0;
  logic       short_press;
  logic       long_press;
  logic       repeat_pulse;
  logic       double_click;
  logic       held;
  logic [2:0] dbg_state;

  press_classifier #(
    .LONG_CYCLES(LONG), .GAP_CYCLES(GAP), .REPEAT_CYCLES(REP), .CNT_W(4)
  ) dut (
    .CLK(CLK), .RST(RST), .enable(enable), .btn_state(btn_state),
    .short_press(short_press), .long_press(long_press),
    .repeat_pulse(repeat_pulse), .double_click(double_click),
    .held(held), .dbg_state(dbg_state)
  );

  // Clock/reset
  always #5 CLK = ~CLK;

  typedef struct {
    logic       btn;
    logic       en;
    logic [4:0] exp;
  } vec_t;

  vec_t       vq[$];
  logic [4:0] exp_q[$];
  int         n_vec = 0;
  int         n_err = 0;
  bit         rb[RN];
  logic [4:0] re[RN];

  function automatic logic [4:0] act_word();
    return {held, double_click, repeat_pulse, long_press, short_press};
  endfunction

  // Scoreboard compare
  task automatic check(input string name, input logic [4:0] act, input logic [4:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b (held,dbl,rep,long,short) at %0t",
               name, act, exp, $time);
    end
  endtask

  task automatic add(input logic btn, input logic en, input int n, input logic [4:0] exp);
    vec_t v;
    v.btn = btn; v.en = en; v.exp = exp;
    for (int i = 0; i < n; i++) vq.push_back(v);
  endtask

  // Driver: one sample per cycle, outputs checked 1 time unit after the edge
  task automatic run_table(input string name);
    vec_t v;
    while (vq.size() > 0) begin
      v = vq.pop_front();
      @(negedge CLK);
      btn_state = v.btn;
      enable    = v.en;
      @(posedge CLK);
      #1;
      check(name, act_word(), v.exp);
    end
  endtask

  task automatic do_reset(input logic b);
    @(negedge CLK);
    RST = 1'b1;
    btn_state = b;
    enable = 1'b1;
    repeat (2) @(negedge CLK);
    check("reset_outputs", act_word(), E0);
    check("reset_state", {2'b00, dbg_state}, 5'd0);
    RST = 1'b0;
  endtask

  function automatic int run_len(input int from, input bit lvl);
    int n = 0;
    while (from + n < RN && rb[from + n] == lvl) n++;
    return n;
  endfunction

  // Reference model: classifies the whole sample stream by run lengths.
  // Sample index k's result is visible right after the k-th clock edge.
  function automatic void build_model();
    int s, r, h, j, l, k2, h2;
    bit prev;
    for (int i = 0; i < RN; i++) re[i] = E0;
    s = 0;
    while (s < RN) begin
      r = -1;
      for (int m = s; m < RN; m++) begin
        prev = (m == 0) ? 1'b1 : rb[m-1];
        if (rb[m] && !prev) begin
          r = m;
          break;
        end
      end
      if (r < 0) break;
      h = run_len(r, 1'b1);
      for (int k = r; k < r + h; k++) re[k] |= EH;
      if (h >= LONG) begin
        re[r + LONG - 1] |= EL;
        for (int k = r + LONG - 1 + REP; k < r + h; k += REP) re[k] |= ER;
        s = r + h;
      end else begin
        j = r + h;
        if (j >= RN) break;
        l = run_len(j, 1'b0);
        if (l >= GAP) begin
          re[j + GAP - 1] |= ES;
          s = j + GAP;
        end else begin
          k2 = j + l;
          if (k2 >= RN) break;
          h2 = run_len(k2, 1'b1);
          for (int k = k2; k < k2 + h2; k++) re[k] |= EH;
          if (k2 + h2 < RN) re[k2 + h2] |= ED;
          s = k2 + h2;
        end
      end
    end
  endfunction

  initial begin
    int p;
    bit lvl;
    int len;

    // Directed table: short, long+repeat, double, gap edges, enable
    do_reset(1'b0);
    add(0, 1, 2, E0);
    add(1, 1, 3, EH);                         // short press
    add(0, 1, 3, E0); add(0, 1, 1, ES); add(0, 1, 6, E0);
    add(1, 1, 7, EH); add(1, 1, 1, EH | EL);  // long press + 2 repeats
    add(1, 1, 2, EH); add(1, 1, 1, EH | ER);
    add(1, 1, 2, EH); add(1, 1, 1, EH | ER);
    add(1, 1, 1, EH); add(0, 1, 6, E0);
    add(1, 1, 2, EH); add(0, 1, 2, E0);       // double click
    add(1, 1, 2, EH); add(0, 1, 1, ED); add(0, 1, 5, E0);
    add(1, 1, 2, EH); add(0, 1, 3, E0);       // gap of exactly GAP lows
    add(0, 1, 1, ES); add(0, 1, 3, E0);
    add(1, 1, 2, EH); add(0, 1, 3, E0);       // rise on expiry sample wins
    add(1, 1, 2, EH); add(0, 1, 1, ED); add(0, 1, 4, E0);
    add(1, 1, 7, EH); add(0, 1, 3, E0);       // fall on threshold sample wins
    add(0, 1, 1, ES); add(0, 1, 3, E0);
    add(1, 1, 3, EH); add(1, 0, 3, E0);       // enable dropped mid-press
    add(1, 1, 3, E0); add(0, 1, 2, E0);
    add(1, 1, 2, EH); add(0, 1, 3, E0); add(0, 1, 1, ES); add(0, 1, 3, E0);
    add(1, 1, 2, EH); add(0, 1, 2, E0);       // enable low suppresses short
    add(0, 0, 4, E0); add(0, 1, 4, E0);
    run_table("directed");

    // Asynchronous reset while in LONG_HOLD with a pulse showing
    do_reset(1'b0);
    add(0, 1, 2, E0);
    add(1, 1, 7, EH); add(1, 1, 1, EH | EL);
    run_table("enter_long_hold");
    #1;
    RST = 1'b1;
    #1;
    check("async_reset_outputs", act_word(), E0);
    check("async_reset_state", {2'b00, dbg_state}, 5'd0);

    // Button held through reset release is ignored until seen low
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    add(1, 1, 12, E0);
    add(0, 1, 2, E0);
    add(1, 1, 2, EH); add(0, 1, 3, E0); add(0, 1, 1, ES); add(0, 1, 2, E0);
    run_table("held_through_reset");

    // Randomized run against the reference model
    p = 0;
    lvl = 1'b1;
    while (p < RN) begin
      len = (($urandom_range(0, 3) == 0) ? $urandom_range(1, 5) : $urandom_range(1, 14));
      for (int i = 0; i < len && p < RN; i++) begin
        rb[p] = lvl;
        p++;
      end
      lvl = ~lvl;
    end
    build_model();
    for (int i = 0; i < RN; i++) exp_q.push_back(re[i]);
    do_reset(1'b1);
    for (int i = 0; i < RN; i++) begin
      @(negedge CLK);
      btn_state = rb[i];
      enable = 1'b1;
      @(posedge CLK);
      #1;
      check("random", act_word(), exp_q.pop_front());
    end

    // Final report
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
